// File: rtl/fp_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : fp_result_collector
// Description : Receiving end of the FP result path. Classifies each incoming
//               result beat, stores {class, word} in a first-word-fall-through
//               FIFO drained over ready/valid, and keeps saturating drop/NaN/
//               infinity statistics plus a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_result_collector #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [EXP_WIDTH+FRAC_WIDTH:0]   fp_i,
  input  logic                            valid_i,
  input  logic                            clr_i,
  input  logic                            rd_ready_i,
  output logic                            rd_valid_o,
  output logic [EXP_WIDTH+FRAC_WIDTH:0]   rd_data_o,
  output logic [2:0]                      rd_class_o,
  output logic [$clog2(DEPTH):0]          count_o,
  output logic                            overflow_o,
  output logic [CNT_WIDTH-1:0]            drop_cnt_o,
  output logic [CNT_WIDTH-1:0]            nan_cnt_o,
  output logic [CNT_WIDTH-1:0]            inf_cnt_o
);

  localparam int FP_WIDTH = 1 + EXP_WIDTH + FRAC_WIDTH;
  localparam int AW       = $clog2(DEPTH);
  localparam int ENTRY_W  = FP_WIDTH + 3;

  localparam logic [AW:0]          FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]          COUNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]        PTR_ONE    = AW'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  localparam logic [2:0] CLS_ZERO = 3'd0;
  localparam logic [2:0] CLS_SUB  = 3'd1;
  localparam logic [2:0] CLS_NORM = 3'd2;
  localparam logic [2:0] CLS_INF  = 3'd3;
  localparam logic [2:0] CLS_QNAN = 3'd4;
  localparam logic [2:0] CLS_SNAN = 3'd5;

  logic [EXP_WIDTH-1:0]  exp_w;
  logic [FRAC_WIDTH-1:0] frac_w;
  logic [2:0]            cls_w;

  logic [ENTRY_W-1:0]    mem_q [DEPTH];
  logic [ENTRY_W-1:0]    head_w;

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_WIDTH-1:0]  nan_cnt_q, nan_cnt_d;
  logic [CNT_WIDTH-1:0]  inf_cnt_q, inf_cnt_d;

  logic                  full_w, pop_w, push_w, drop_w;

  // Counters hold at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Classify the incoming word; the sign bit plays no part.
  always_comb begin
    exp_w  = fp_i[FP_WIDTH-2 -: EXP_WIDTH];
    frac_w = fp_i[FRAC_WIDTH-1:0];
    cls_w  = CLS_NORM;
    if (exp_w == '0) begin
      cls_w = (frac_w == '0) ? CLS_ZERO : CLS_SUB;
    end else if (&exp_w) begin
      if (frac_w == '0) begin
        cls_w = CLS_INF;
      end else if (frac_w[FRAC_WIDTH-1]) begin
        cls_w = CLS_QNAN;
      end else begin
        cls_w = CLS_SNAN;
      end
    end
  end

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign full_w = (count_q == FULL_COUNT);
  assign pop_w  = rd_valid_o && rd_ready_i;
  assign push_w = valid_i && (!full_w || pop_w);
  assign drop_w = valid_i && !push_w;

  // Next-state for pointers, occupancy and statistics; clear overrides increments.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    nan_cnt_d  = nan_cnt_q;
    inf_cnt_d  = inf_cnt_q;

    if (pop_w) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push_w) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    case ({push_w, pop_w})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase

    if (drop_w) begin
      drop_cnt_d = sat_inc(drop_cnt_q);
      overflow_d = 1'b1;
    end
    if (push_w && (cls_w == CLS_QNAN || cls_w == CLS_SNAN)) begin
      nan_cnt_d = sat_inc(nan_cnt_q);
    end
    if (push_w && (cls_w == CLS_INF)) begin
      inf_cnt_d = sat_inc(inf_cnt_q);
    end

    if (clr_i) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
      nan_cnt_d  = '0;
      inf_cnt_d  = '0;
    end
  end

  // Control and statistics registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      nan_cnt_q  <= '0;
      inf_cnt_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      nan_cnt_q  <= nan_cnt_d;
      inf_cnt_q  <= inf_cnt_d;
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push_w) begin
      mem_q[wr_ptr_q] <= {cls_w, fp_i};
    end
  end

  assign head_w     = mem_q[rd_ptr_q];
  assign rd_valid_o = (count_q != '0);
  assign rd_data_o  = head_w[FP_WIDTH-1:0];
  assign rd_class_o = head_w[ENTRY_W-1 -: 3];
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;
  assign nan_cnt_o  = nan_cnt_q;
  assign inf_cnt_o  = inf_cnt_q;

endmodule
`default_nettype wire

// File: doc/fp_result_collector.md
Name: fp_result_collector

Overview:
- Receiving end of the floating-point unit result path.
- Captures every result beat presented on fp_i/valid_i, classifies it (zero/subnormal/normal/inf/qNaN/sNaN) and stores data plus class in a FIFO.
- The FIFO is drained through a ready/valid read port.
- Keeps saturating statistics counters: drops, NaNs, infinities. Sits between an FP pipeline (no backpressure) and a slower consumer or checker.

Parameters:
- EXP_WIDTH, 8, exponent field width.
- FRAC_WIDTH, 23, fraction field width.
- DEPTH, 16, FIFO entries; power of two, >= 2.
- CNT_WIDTH, 16, width of each statistics counter.
- FP_WIDTH (local), 1+EXP_WIDTH+FRAC_WIDTH, encoded word width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- fp_i  in  FP_WIDTH  result word {sign, exp, frac}.
- valid_i  in  1  fp_i valid this cycle; no ready, producer never stalls.
- clr_i  in  1  synchronous clear of statistics counters and overflow_o.
- rd_ready_i  in  1  consumer accepts head entry.
- rd_valid_o  out  1  FIFO non-empty.
- rd_data_o  out  FP_WIDTH  head entry word.
- rd_class_o  out  3  head entry class.
- count_o  out  $clog2(DEPTH)+1  current occupancy.
- overflow_o  out  1  sticky: at least one beat dropped.
- drop_cnt_o  out  CNT_WIDTH  beats dropped while full.
- nan_cnt_o  out  CNT_WIDTH  accepted qNaN+sNaN beats.
- inf_cnt_o  out  CNT_WIDTH  accepted +/-inf beats.

Behaviour:
- Async reset: pointers, count_o, all counters, overflow_o = 0; rd_valid_o = 0. FIFO storage is not reset. Reset mid-stream discards all contents; the first beat after deassertion is handled normally.
- Classification (combinational on fp_i, stored with the word):
  - 0 zero: exp=0, frac=0.
  - 1 subnormal: exp=0, frac!=0.
  - 2 normal: exp neither all-0 nor all-1.
  - 3 inf: exp all-1, frac=0.
  - 4 qNaN: exp all-1, frac MSB=1.
  - 5 sNaN: exp all-1, frac MSB=0, frac!=0.
  - 6, 7 never produced.
  - Sign is ignored for class.
- Write: on a rising edge with valid_i=1 the beat is accepted if not full, or if full and a pop occurs in the same cycle.
- Read: a pop occurs when rd_valid_o && rd_ready_i.
- FWFT: rd_data_o/rd_class_o show the head entry whenever rd_valid_o=1; they are don't-care when rd_valid_o=0.
- Latency: a beat accepted at edge N is visible on rd_valid_o/rd_data_o after edge N. There is no same-cycle bypass when empty.
- Simultaneous push and pop: occupancy unchanged.
  - When empty, only the push has effect, since rd_valid_o=0 means no pop.
  - When full, both succeed and nothing is dropped.
- Full, valid_i=1, no pop: beat discarded; drop_cnt_o += 1; overflow_o set.
- Pointers wrap modulo DEPTH. count_o ranges 0..DEPTH; full is count_o==DEPTH.
- nan_cnt_o/inf_cnt_o increment only on accepted beats of class 4/5 or 3 respectively.
- All counters saturate at 2^CNT_WIDTH-1.
- clr_i=1: counters and overflow_o go to 0 on the next edge; clear wins over a same-cycle increment. FIFO contents and pointers are unaffected.
- rd_ready_i while empty has no effect.

Test Plan:
- Classification (defaults): push 0x80000000, 0x00000001, 0x3F800000, 0xFF800000, 0x7FC00000, 0x7F800001 on consecutive cycles, rd_ready_i=1 -> pops return the same words in order with classes 0,1,2,3,4,5; nan_cnt_o=2, inf_cnt_o=1, drop_cnt_o=0.
- Latency: single push 0x40000000 at edge N into empty FIFO -> rd_valid_o=0 before edge N, =1 after edge N with rd_data_o=0x40000000; count_o=1.
- Overflow: rd_ready_i=0, push 20 beats 0x3F800000+k (k=0..19), DEPTH=16 -> count_o=16, drop_cnt_o=4, overflow_o=1; draining returns k=0..15 in order.
- Full + simultaneous pop: fill to 16, then push 0x7F800000 with rd_ready_i=1 in the same cycle -> no drop, count_o stays 16, inf_cnt_o=1, last entry drained is 0x7F800000.
- Wrap and saturation: CNT_WIDTH=2, continuous push/pop of 0x7FC00000 for 40 beats -> no data loss, pointers wrap, nan_cnt_o=3 (saturated); clr_i pulse -> nan_cnt_o=0 next cycle.
- Reset mid-stream: 5 entries queued, assert rst_i asynchronously between edges -> rd_valid_o=0 and count_o=0 immediately; next push after deassertion is the only entry read.
